sr_latch_ctrl: RTL

- Sequencing arbiter that shares one external SR latch between NREQ requesters.
- Each requester asks to set or clear the latch. The block grants requests round-robin and drives exactly one of s_out/r_out for a fixed pulse width.
- After the pulse it checks the latch feedback, acknowledges the requester, then enforces a quiet gap.
- Guarantees the latch never sees s_out=r_out=1.

---
 rtl/sr_latch_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: shares one external SR latch between NREQ requesters.
// Requests are granted round-robin. Each grant drives exactly one of s_out/r_out
// for PULSE_W cycles, checks the latch feedback, acks the requester, then holds
// a GAP_W-cycle quiet gap. s_out and r_out are never high together.
// Optional build macro: SR_SKIP_REDUNDANT_EN. When it is defined, a grant whose
// requested value already matches q_in skips the drive pulse and goes to CHECK.

module sr_latch_ctrl #(
  parameter int NREQ    = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  input  logic            q_in,
  output logic [NREQ-1:0] ack,
  output logic            s_out,
  output logic            r_out,
  output logic            busy,
  output logic            err
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_W > 0) ? (GAP_W - 1) : 0);
  localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] grant_next;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] last_next;
  logic             op_r;
  logic             op_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             err_next;
  logic             s_next;
  logic             r_next;
  logic [NREQ-1:0]  ack_next;
  logic [IDX_W-1:0] pick;
  logic             any_req;

  // Index that is off positions after base, wrapping at NREQ (off is 1..NREQ).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDX_W'(sum);
  endfunction

  // Round-robin pick: first set req bit searching upward from last+1, wrapping.
  // Scanning from the farthest candidate inward lets the nearest one win.
  always_comb begin
    pick    = last;
    any_req = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[wrap_add(last, k)]) begin
        pick    = wrap_add(last, k);
        any_req = 1'b1;
      end
    end
  end

  // Next-state logic; the shared counter times both the pulse and the gap.
  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last;
    op_next    = op_r;
    cnt_next   = cnt;
    err_next   = err;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_next = pick;
          last_next  = pick;
          op_next    = op[pick];
          cnt_next   = PULSE_LOAD;
          state_next = DRIVE;
`ifdef SR_SKIP_REDUNDANT_EN
          if (q_in == op[pick]) state_next = CHECK;
`endif
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          state_next = CHECK;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      CHECK: begin
        if (q_in != op_r) err_next = 1'b1;
        if (GAP_W > 0) begin
          cnt_next   = GAP_LOAD;
          state_next = GAP;
        end else begin
          state_next = IDLE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so the
  // outputs themselves can be plain registers with a clean async reset.
  always_comb begin
    s_next   = (state_next == DRIVE) &  op_next;
    r_next   = (state_next == DRIVE) & ~op_next;
    ack_next = '0;
    if (state_next == CHECK) ack_next = NREQ'(1) << grant_next;
  end

  // State, bookkeeping and registered outputs; reset drops every output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= LAST_INIT;
      op_r  <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
      s_out <= 1'b0;
      r_out <= 1'b0;
      ack   <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      last  <= last_next;
      op_r  <= op_next;
      cnt   <= cnt_next;
      err   <= err_next;
      s_out <= s_next;
      r_out <= r_next;
      ack   <= ack_next;
    end
  end

  assign busy = (state != IDLE);

endmodule
